// File: rtl/vid_rx_pkg.sv
// Shared types and constants for the video stream receive monitor.
package vid_rx_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

    localparam int ERR_W   = 3;
    localparam int ERR_LEN = 0;
    localparam int ERR_DE  = 1;
    localparam int ERR_SAT = 2;

endpackage

// File: rtl/vid_sync_edge.sv
// Input register stage for the de/hs/vs stream plus sync edge pulses.
module vid_sync_edge #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] di_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  vs_rise_o,
    output logic                  vs_fall_o,
    output logic                  hs_rise_o,
    output logic                  hs_fall_o
);

    logic [DATA_WIDTH-1:0] di_q;
    logic                  de_q, hs_q, vs_q;
    logic                  hs_prev_q, vs_prev_q;

    // Syncs reset to their "blank/active" levels so reset release never fakes a vs rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            di_q      <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            di_q      <= di_i;
            de_q      <= de_i;
            hs_q      <= hs_i;
            vs_q      <= vs_i;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
        end
    end

    assign di_o      = di_q;
    assign de_o      = de_q;
    assign hs_o      = hs_q;
    assign vs_o      = vs_q;
    assign vs_rise_o =  vs_q & ~vs_prev_q;
    assign vs_fall_o = ~vs_q &  vs_prev_q;
    assign hs_rise_o =  hs_q & ~hs_prev_q;
    assign hs_fall_o = ~hs_q &  hs_prev_q;

endmodule

// File: rtl/vid_stream_rx_mon.sv
// Per-frame measurement of a de/hs/vs stream: width, height, pixel sum, errors.
module vid_stream_rx_mon
    import vid_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int W_CNT_WIDTH = 13,
    parameter int H_CNT_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic                   frame_done_o,
    output logic [W_CNT_WIDTH-1:0] width_o,
    output logic [H_CNT_WIDTH-1:0] height_o,
    output logic [31:0]            sum_o,
    output logic [15:0]            frame_cnt_o,
    output logic [ERR_W-1:0]       err_o,
    output logic [ERR_W-1:0]       err_sticky_o
);

    logic [DATA_WIDTH-1:0] di_r;
    logic de_r, hs_r, vs_r;
    logic vs_rise, vs_fall, hs_rise, hs_fall;

    vid_sync_edge #(.DATA_WIDTH(DATA_WIDTH)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .di_i      (di_i),
        .de_i      (de_i),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .di_o      (di_r),
        .de_o      (de_r),
        .hs_o      (hs_r),
        .vs_o      (vs_r),
        .vs_rise_o (vs_rise),
        .vs_fall_o (vs_fall),
        .hs_rise_o (hs_rise),
        .hs_fall_o (hs_fall)
    );

    rx_state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SYNC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (!vs_r)   state_d = VBLANK;
            VBLANK:  if (vs_rise) state_d = ACTIVE;
            ACTIVE:  if (vs_fall) state_d = VBLANK;
            default:              state_d = SYNC;
        endcase
    end

    logic is_active, is_vblank;
    logic pix_acc, de_bad, line_end, frame_start, frame_end;

    assign is_active   = (state_q == ACTIVE);
    assign is_vblank   = (state_q == VBLANK);
    assign pix_acc     = is_active && de_r && !hs_r && vs_r;
    assign de_bad      = (state_q != SYNC) && de_r && (hs_r || !vs_r);
    assign line_end    = is_active && (hs_rise || vs_fall);
    assign frame_start = is_vblank && vs_rise;
    assign frame_end   = is_active && vs_fall;

    logic [W_CNT_WIDTH-1:0] line_cnt_q, ref_w_q, line_base;
    logic [H_CNT_WIDTH-1:0] height_q;
    logic [31:0]            sum_q;
    logic [ERR_W-1:0]       err_q;
    logic                   first_seen_q, err_pend_q, commit_q;

    // A pixel on the hs_fall cycle starts a fresh line count.
    assign line_base = hs_fall ? '0 : line_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt_q   <= '0;
            ref_w_q      <= '0;
            height_q     <= '0;
            sum_q        <= '0;
            err_q        <= '0;
            first_seen_q <= 1'b0;
            err_pend_q   <= 1'b0;
        end else if (frame_start) begin
            line_cnt_q        <= '0;
            ref_w_q           <= '0;
            height_q          <= '0;
            sum_q             <= '0;
            first_seen_q      <= 1'b0;
            err_q             <= '0;
            err_q[ERR_DE]     <= err_pend_q | de_bad;
            err_pend_q        <= 1'b0;
        end else begin
            // Stray de during vertical blank is charged to the next frame.
            if (is_vblank && de_bad) err_pend_q <= 1'b1;
            if (is_active && de_bad) err_q[ERR_DE] <= 1'b1;

            if (pix_acc) begin
                sum_q <= sum_q + 32'(di_r);
                if (&line_base) begin
                    line_cnt_q     <= line_base;
                    err_q[ERR_SAT] <= 1'b1;
                end else begin
                    line_cnt_q <= line_base + 1'b1;
                end
            end else if (is_active && hs_fall) begin
                line_cnt_q <= '0;
            end

            if (line_end) begin
                line_cnt_q <= '0;
                if (line_cnt_q != '0) begin
                    if (&height_q) err_q[ERR_SAT] <= 1'b1;
                    else           height_q <= height_q + 1'b1;
                    if (!first_seen_q) begin
                        ref_w_q      <= line_cnt_q;
                        first_seen_q <= 1'b1;
                    end else if (line_cnt_q != ref_w_q) begin
                        err_q[ERR_LEN] <= 1'b1;
                    end
                end
            end
        end
    end

    // Commit one cycle after the frame closes so the last line's result is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_q     <= 1'b0;
            frame_done_o <= 1'b0;
            width_o      <= '0;
            height_o     <= '0;
            sum_o        <= '0;
            frame_cnt_o  <= '0;
            err_o        <= '0;
            err_sticky_o <= '0;
        end else begin
            commit_q     <= frame_end;
            frame_done_o <= commit_q;
            if (commit_q) begin
                width_o      <= ref_w_q;
                height_o     <= height_q;
                sum_o        <= sum_q;
                err_o        <= err_q;
                frame_cnt_o  <= frame_cnt_o + 16'd1;
                err_sticky_o <= err_sticky_o | err_q;
            end
        end
    end

endmodule

// File: tb/tb_vid_stream_rx_mon.sv
// Frame-level bench for vid_stream_rx_mon: table of frames plus reset/glitch sequences.
module tb_vid_stream_rx_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] di_i;
    logic        de_i, hs_i, vs_i;
    logic        frame_done_o;
    logic [12:0] width_o;
    logic [11:0] height_o;
    logic [31:0] sum_o;
    logic [15:0] frame_cnt_o;
    logic [2:0]  err_o, err_sticky_o;

    vid_stream_rx_mon dut (
        .clk          (clk),
        .rst          (rst),
        .di_i         (di_i),
        .de_i         (de_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .frame_done_o (frame_done_o),
        .width_o      (width_o),
        .height_o     (height_o),
        .sum_o        (sum_o),
        .frame_cnt_o  (frame_cnt_o),
        .err_o        (err_o),
        .err_sticky_o (err_sticky_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] w;
        logic [11:0] h;
        logic [31:0] s;
        logic [2:0]  e;
        logic [15:0] c;
        logic [2:0]  st;
    } exp_t;

    typedef struct {
        int   per;
        int   nl;
        int   l1;
        bit   gl;
        bit   sim;
        exp_t ex;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, n_push = 0, n_pulse = 0;
    int   cyc = 0, vs_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && frame_done_o) begin
            exp_t e;
            n_pulse++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got frame_done at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                chk("width", 32'(width_o), 32'(e.w));
                chk("height", 32'(height_o), 32'(e.h));
                chk("sum", sum_o, e.s);
                chk("err", 32'(err_o), 32'(e.e));
                chk("frame_cnt", 32'(frame_cnt_o), 32'(e.c));
                chk("err_sticky", 32'(err_sticky_o), 32'(e.st));
                chk("latency", 32'(cyc - vs_drop), 32'd3);
            end
        end
    end

    task automatic send_frame(input int per, input int nl, input int l1, input bit gl,
                              input bit sim, input bit rmid, input bit psh, input exp_t e);
        bit closed = 1'b0;
        if (psh) begin
            sb.push_back(e);
            n_push++;
        end
        vs_i = 1'b0; hs_i = 1'b1; de_i = 1'b0; di_i = '0;
        repeat (4) @(negedge clk);
        vs_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int y = 0; y < nl; y++) begin
            int len;
            hs_i = 1'b0;
            if (rmid && y == 1) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            len = (y == 1) ? l1 : 4;
            for (int x = 0; x < len; x++) begin
                de_i = 1'b1; di_i = 24'(x);
                @(negedge clk);
                de_i = 1'b0; di_i = '0;
                repeat (per - 1) @(negedge clk);
            end
            if (sim && y == nl - 1) begin
                hs_i = 1'b1; vs_i = 1'b0; vs_drop = cyc;
                closed = 1'b1;
            end else begin
                hs_i = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    de_i = gl && y == 0 && k == 4;
                    di_i = de_i ? 24'd100 : 24'd0;
                    @(negedge clk);
                end
                de_i = 1'b0; di_i = '0;
            end
        end
        if (!closed) begin
            vs_i = 1'b0; vs_drop = cyc;
        end
        repeat (8) @(negedge clk);
    endtask

    vec_t tbl[7];
    exp_t none;

    initial begin
        // Frame table: de period, lines, line-1 length, hs glitch, simultaneous vs/hs edge.
        tbl[0] = '{1, 3, 4, 0, 0, '{13'd4, 12'd3, 32'd18, 3'b000, 16'd1, 3'b000}};
        tbl[1] = '{2, 3, 4, 0, 0, '{13'd4, 12'd3, 32'd18, 3'b000, 16'd2, 3'b000}};
        tbl[2] = '{2, 3, 4, 0, 0, '{13'd4, 12'd3, 32'd18, 3'b000, 16'd3, 3'b000}};
        tbl[3] = '{4, 3, 4, 0, 0, '{13'd4, 12'd3, 32'd18, 3'b000, 16'd4, 3'b000}};
        tbl[4] = '{1, 3, 5, 0, 0, '{13'd4, 12'd3, 32'd22, 3'b001, 16'd5, 3'b001}};
        tbl[5] = '{3, 3, 4, 0, 1, '{13'd4, 12'd3, 32'd18, 3'b000, 16'd6, 3'b001}};
        tbl[6] = '{1, 0, 4, 0, 0, '{13'd0, 12'd0, 32'd0,  3'b000, 16'd7, 3'b001}};
        none   = '{13'd0, 12'd0, 32'd0, 3'b000, 16'd0, 3'b000};

        rst = 1'b1; vs_i = 1'b0; hs_i = 1'b1; de_i = 1'b0; di_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(frame_done_o), 32'd0);
        chk("rst_width", 32'(width_o), 32'd0);
        chk("rst_height", 32'(height_o), 32'd0);
        chk("rst_sum", sum_o, 32'd0);
        chk("rst_cnt", 32'(frame_cnt_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_sticky", 32'(err_sticky_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            send_frame(tbl[i].per, tbl[i].nl, tbl[i].l1, tbl[i].gl, tbl[i].sim, 1'b0, 1'b1, tbl[i].ex);

        // Reset clears the sticky errors, then a de glitch during hs blank.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_cnt", 32'(frame_cnt_o), 32'd0);
        chk("rst2_sticky", 32'(err_sticky_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send_frame(1, 3, 4, 1'b1, 1'b0, 1'b0, 1'b1, '{13'd4, 12'd3, 32'd18, 3'b010, 16'd1, 3'b010});
        send_frame(2, 3, 4, 1'b0, 1'b0, 1'b0, 1'b1, '{13'd4, 12'd3, 32'd18, 3'b000, 16'd2, 3'b010});

        // Reset inside line 1 with vs high: partial frame must not be reported.
        send_frame(1, 3, 4, 1'b0, 1'b0, 1'b1, 1'b0, none);
        chk("rmid_cnt", 32'(frame_cnt_o), 32'd0);
        send_frame(1, 3, 4, 1'b0, 1'b0, 1'b0, 1'b1, '{13'd4, 12'd3, 32'd18, 3'b000, 16'd1, 3'b000});

        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("pulse_count", 32'(n_pulse), 32'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vid_stream_rx_mon.md
Name: vid_stream_rx_mon

Overview:
- Receive end of the de/hs/vs video stream driven by the filter benches and emitted by the filter cores.
- Sits on a filter output (do_o/de_o/hs_o/vs_o) and measures each frame: active width, height, pixel sum and protocol errors.
- Reports results once per frame, so benches and on-chip debug can check a stream without dumping images.

Parameters:
DATA_WIDTH, 24, pixel bus width (PIXEL_WIDTH*3 for colour streams)
W_CNT_WIDTH, 13, width of the pixels-per-line counter (max 8191)
H_CNT_WIDTH, 12, width of the lines-per-frame counter (max 4095)

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-high
di_i  in  DATA_WIDTH  pixel data, valid when de_i=1
de_i  in  1  pixel valid
hs_i  in  1  line sync: 0 = active line, 1 = horizontal blank
vs_i  in  1  frame sync: 1 = frame active, 0 = vertical blank
frame_done_o  out  1  one-cycle pulse when results are updated
width_o  out  W_CNT_WIDTH  pixel count of the first line of the last frame
height_o  out  H_CNT_WIDTH  non-empty lines in the last frame
sum_o  out  32  sum mod 2^32 of zero-extended di_i over the last frame
frame_cnt_o  out  16  completed frames since reset, wraps
err_o  out  3  per-frame errors of the last frame: [0] line length mismatch, [1] de outside active region, [2] counter saturation
err_sticky_o  out  3  OR of all err_o since reset

Behaviour:
- Reset (async assert, sync release): all outputs 0; internal counters 0; FSM = SYNC.
- All inputs are registered once before use. Edges are detected against the registered previous value:
  - vs_rise: vs 0→1; vs_fall: vs 1→0.
  - hs_fall: line start; hs_rise: line end.
- FSM states:
  - SYNC: waits for registered vs=0; goes to VBLANK. A frame already in progress at reset release is never reported.
  - VBLANK: on vs_rise, clears the frame accumulators (line counter, sum, first-line latch, frame error bits) and goes to ACTIVE.
  - ACTIVE: on vs_fall, goes to VBLANK and commits the frame.
- Pixel accept: in ACTIVE with de=1, hs=0, vs=1.
  - Line pixel counter increments, saturating at all-ones; saturation sets err[2].
  - sum += di.
- de=1 with hs=1 or vs=0, in any state except SYNC:
  - pixel ignored.
  - sets err[1] of the current frame.
  - in VBLANK, the error is applied to the next frame.
- Line end (hs_rise in ACTIVE, or vs_fall while in a line):
  - If the line count is 0, the line is ignored.
  - Otherwise height increments (saturating, sets err[2]).
  - The first non-empty line's count is latched as the reference width; later lines differing from it set err[0].
  - The line counter clears.
- Simultaneous vs_fall and hs_rise on the same cycle (the normal bench pattern): the last line is closed first, then the frame is committed. The last line is counted and checked.
- vs_fall mid-line (hs still 0): the line is closed as above, then the frame is committed.
- Commit latency: frame_done_o is high for exactly one cycle, 2 clk after the first clk edge at which vs_i=0 is sampled. On that same cycle:
  - width_o, height_o, sum_o and err_o take the new values.
  - frame_cnt_o increments.
  - err_sticky_o |= err_o.
- Outputs hold their values between commits.
- A frame with zero non-empty lines is still committed, with width=0 and height=0.
- Throughput: one pixel per clk, no back-pressure. Any DE duty cycle is supported (pixels every cycle, every 2nd cycle, every 4th cycle, etc.).
- Reset mid-frame: everything clears immediately; the partial frame is discarded via the SYNC state.

Decomposition:
- Package vid_rx_pkg:
  - FSM enum: SYNC, VBLANK, ACTIVE.
  - Error bit index constants: ERR_LEN=0, ERR_DE=1, ERR_SAT=2.
  - Constant ERR_W=3.
- Sub-module vid_sync_edge: registers de/hs/vs/di and produces vs_rise, vs_fall, hs_fall, hs_rise pulses plus the delayed data.

Test Plan:
- 4x3 frame, di=x (0..3), de every cycle, hs high 10 clk between lines -> one frame_done pulse, width=4, height=3, sum=18, err=0, frame_cnt=1.
- Same frame with de every 2nd clk, sent twice -> two pulses, identical results, frame_cnt=2, err_sticky=0.
- 4x3 frame whose line 1 has 5 pixels (x=0..4) -> width=4, height=3, sum=22, err=3'b001.
- de=1 with di=100 for one cycle during hs=1 inside the frame, otherwise the 4x3 frame -> sum=18 (pixel not counted), err=3'b010, err_sticky=3'b010 persists through a following clean frame.
- Assert rst during line 1 with vs held high, then finish that frame and send a clean 4x3 frame -> no pulse for the partial frame; one pulse for the clean frame, frame_cnt=1.
- vs_i and hs_i change on the same clk at the end of the last line of the 4x3 frame -> height=3, err=0; pulse appears 2 clk after vs=0 is first sampled.
